// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier datapath.
package booth_pkg;

  // Datapath sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    DECIDE,
    EXEC,
    DONE
  } booth_state_t;

  // Booth pair encodings seen on p = {Q[0],Q[-1]}.
  localparam logic [1:0] P_ADD = 2'b01;
  localparam logic [1:0] P_SUB = 2'b10;

  // Width of the count/n_count bus shared with the controller.
  localparam int unsigned COUNT_W = 8;

endpackage

// File: rtl/booth_addsub.sv
// Combinational adder/subtractor used for the Booth accumulate step.
module booth_addsub #(
  parameter int unsigned W = 65
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o
);

  // A - B when sub_i is set, otherwise A + B.
  always_comb begin
    sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);
  end

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 signed Booth multiplier datapath: M, A, Q, Q[-1] and step count.
// Optional feature macro: BOOTH_PRODUCT_LATCH_EN (product held in its own register,
// updated only when the FSM enters DONE).
module booth_datapath #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s1,
  input  logic                 s2,
  input  logic                 s3,
  input  logic                 op_done,
  input  logic [COUNT_W-1:0]   n_count,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [1:0]           p,
  output logic [COUNT_W-1:0]   count,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  import booth_pkg::*;

  booth_state_t         state_q, state_d;
  // A carries one extra bit so A - M cannot overflow for M = -2^(WIDTH-1).
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 qm1_q, qm1_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [WIDTH:0]       m_ext;
  logic [WIDTH:0]       a_sum;
  logic [WIDTH:0]       a_next;
  logic                 last_step;

  assign m_ext     = {m_q[WIDTH-1], m_q};
  assign last_step = (count_q == COUNT_W'(WIDTH));

  booth_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a_i   (a_q),
    .b_i   (m_ext),
    .sub_i (s2),
    .sum_o (a_sum)
  );

  // Accumulate only when the controller asked for an add/sub this step.
  assign a_next = s3 ? a_sum : a_q;

  // Next-state and datapath register updates; a load strobe overrides everything.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    if (s1) begin
      m_d     = mcand;
      q_d     = mplier;
      a_d     = '0;
      qm1_d   = 1'b0;
      count_d = '0;
      state_d = DECIDE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        DECIDE: begin
          state_d = (last_step || op_done) ? DONE : EXEC;
        end
        EXEC: begin
          // Arithmetic right shift of {A', Q, Q[-1]} by one.
          a_d     = {a_next[WIDTH], a_next[WIDTH:1]};
          q_d     = {a_next[0], q_q[WIDTH-1:1]};
          qm1_d   = q_q[0];
          count_d = n_count;
          state_d = op_done ? DONE : DECIDE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
    end
  end

`ifdef BOOTH_PRODUCT_LATCH_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;

  // Capture the finished result on the cycle the FSM enters DONE.
  always_comb begin
    prod_d = prod_q;
    if (state_d == DONE && state_q != DONE) begin
      prod_d = {a_d[WIDTH-1:0], q_d};
    end
  end

  // Product holding register; survives later loads until the next DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign product = prod_q;
`else
  // Product is only meaningful while done is high.
  assign product = {a_q[WIDTH-1:0], q_q};
`endif

  // Status outputs decoded from registers.
  always_comb begin
    p     = {q_q[0], qm1_q};
    count = count_q;
    busy  = (state_q == DECIDE) || (state_q == EXEC);
    done  = (state_q == DONE);
  end

endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath (WIDTH = 8) with a cycle-level reference model.
module tb_booth_datapath;

  localparam int W  = 8;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            s1 = 1'b0;
  logic            s2 = 1'b0;
  logic            s3 = 1'b0;
  logic            op_done = 1'b0;
  logic [CW-1:0]   n_count = '0;
  logic [W-1:0]    mcand = '0;
  logic [W-1:0]    mplier = '0;
  logic [1:0]      p;
  logic [CW-1:0]   count;
  logic [2*W-1:0]  product;
  logic            busy;
  logic            done;

  booth_datapath #(
    .WIDTH   (W),
    .COUNT_W (CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s1      (s1),
    .s2      (s2),
    .s3      (s3),
    .op_done (op_done),
    .n_count (n_count),
    .mcand   (mcand),
    .mplier  (mplier),
    .p       (p),
    .count   (count),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] smul(input logic [W-1:0] x, input logic [W-1:0] y);
    int xi;
    int yi;
    xi = $signed(x);
    yi = $signed(y);
    return (2*W)'(xi * yi);
  endfunction

  // Reference model: mode 0 idle, 1 running, 2 done; k = edges since load.
  int             mode = 0;
  int             k = 0;
  int             cnt = 0;
  logic [W-1:0]   ma = '0;
  logic [W-1:0]   mb = '0;
  bit             prod_known = 1'b1;
  logic [2*W-1:0] lat_prod = '0;
  bit             lat_known = 1'b1;
  bit             mvalid = 1'b0;

  task automatic model_finish();
    mode = 2;
    prod_known = (cnt == W);
`ifdef BOOTH_PRODUCT_LATCH_EN
    lat_prod  = smul(ma, mb);
    lat_known = prod_known;
`endif
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mode = 0; k = 0; cnt = 0; ma = '0; mb = '0;
      prod_known = 1'b1; lat_prod = '0; lat_known = 1'b1; mvalid = 1'b1;
    end else if (s1) begin
      mode = 1; k = 0; cnt = 0; ma = mcand; mb = mplier; prod_known = 1'b1;
    end else if (mode == 1) begin
      if (k % 2 == 1) begin
        cnt++;
        k++;
        if (op_done) model_finish();
      end else if (op_done || cnt == W) begin
        model_finish();
      end else begin
        k++;
      end
    end
  end

  // Controller stand-in: Booth selects and count+1 during a step, noise otherwise.
  always @(negedge clk) begin
    if (mode == 1 && k % 2 == 1 && cnt < W) begin
      logic bj, bjm1;
      bj   = mb[cnt];
      bjm1 = (cnt > 0) ? mb[cnt-1] : 1'b0;
      s3 = bj ^ bjm1;
      s2 = bj;
      n_count = CW'(cnt + 1);
    end else begin
      s3 = 1'($urandom);
      s2 = 1'($urandom);
      n_count = CW'($urandom);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      logic [1:0]     pe;
      logic [2*W-1:0] full;
      check("busy", 64'(busy), 64'(mode == 1));
      check("done", 64'(done), 64'(mode == 2));
      check("count", 64'(count), 64'(cnt));
      full = smul(ma, mb);
      if (mode == 1) begin
        if (cnt < W) pe = {mb[cnt], (cnt > 0) ? mb[cnt-1] : 1'b0};
        else         pe = {full[0], mb[W-1]};
        check("p", 64'(p), 64'(pe));
      end
      if (mode == 0) begin
        check("p_idle", 64'(p), 64'd0);
        check("product_idle", 64'(product), 64'd0);
      end
`ifdef BOOTH_PRODUCT_LATCH_EN
      if (lat_known) check("product_latched", 64'(product), 64'(lat_prod));
`else
      if (mode == 2 && prod_known) check("product", 64'(product), 64'(full));
`endif
    end
  end

  // Load one operation from a negedge and wait for done (bounded).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int odk, input string name);
    int cyc;
    s1 = 1'b1; mcand = a; mplier = b; op_done = 1'b0;
    @(negedge clk);
    s1 = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      op_done = (cyc == odk);
      @(negedge clk);
      cyc++;
    end
    op_done = 1'b0;
    if (!done) begin
      check({name, "_timeout"}, 64'(done), 64'd1);
    end else if (odk < 0) begin
      check({name, "_latency"}, 64'(cyc), 64'(2*W + 1));
      check({name, "_product"}, 64'(product), 64'(exp));
      check({name, "_count"}, 64'(count), 64'(W));
    end
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    @(negedge clk);

    run_op(8'd3, 8'hFB, 16'hFFF1, -1, "3x-5");

`ifdef BOOTH_PRODUCT_LATCH_EN
    s1 = 1'b1; mcand = 8'd2; mplier = 8'd2;
    @(negedge clk);
    s1 = 1'b0;
    repeat (4) @(negedge clk);
    check("latch_hold", 64'(product), 64'hFFF1);
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("latch_new", 64'(product), 64'h0004);
`endif

    run_op(8'h80, 8'h80, 16'h4000, -1, "m128sq");
    run_op(8'h00, 8'h5A, 16'h0000, -1, "zero");
    run_op(8'h7F, 8'h7F, 16'h3F01, -1, "maxsq");

    // Abort: reload during the fourth EXEC step.
    s1 = 1'b1; mcand = 8'd7; mplier = 8'hFD;
    @(negedge clk);
    s1 = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_count", 64'(count), 64'd3);
    run_op(8'd2, 8'd3, 16'd6, -1, "abort2x3");

    // Reset during EXEC wins over a simultaneous load.
    s1 = 1'b1; mcand = 8'h55; mplier = 8'h33;
    @(negedge clk);
    s1 = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1; s1 = 1'b1; mcand = 8'd9; mplier = 8'd9;
    @(negedge clk);
    reset = 1'b0; s1 = 1'b0;
    check("rexec_busy", 64'(busy), 64'd0);
    check("rexec_done", 64'(done), 64'd0);
    check("rexec_count", 64'(count), 64'd0);
    check("rexec_product", 64'(product), 64'd0);
    check("rexec_p", 64'(p), 64'd0);
    repeat (3) @(negedge clk);
    check("rexec_stay", 64'(busy | done), 64'd0);

    // Randomized operations, some terminated early by op_done.
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      int odk;
      a = W'($urandom);
      b = W'($urandom);
      if (i == 0) a = 8'h80;
      if (i == 1) b = 8'h80;
      if (i == 2) b = 8'hFF;
      odk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_op(a, b, smul(a, b), odk, "rnd");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
